// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: buffers parsed instruction pairs and issues them to two
// execution ports. Pairs without a hazard go out together. Others go out one slot
// at a time, and the scheduler holds while a branch is outstanding.
module issue_scheduler #(
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic        clock_i,
  input  logic        nReset_i,
  input  logic        flush_i,
  input  logic        enable_i,
  input  logic        isBranch_i1,
  input  logic        isBranch_i2,
  input  logic        format_i1,
  input  logic        format_i2,
  input  logic [6:0]  opcode_i1,
  input  logic [6:0]  opcode_i2,
  input  logic [4:0]  reg_i1,
  input  logic [4:0]  reg_i2,
  input  logic [15:0] operand_i1,
  input  logic [15:0] operand_i2,
  output logic        stall_o,
  output logic        issueValid_o1,
  output logic        issueValid_o2,
  input  logic        issueReady_i1,
  input  logic        issueReady_i2,
  output logic        isBranch_o1,
  output logic        isBranch_o2,
  output logic        format_o1,
  output logic        format_o2,
  output logic [6:0]  opcode_o1,
  output logic [6:0]  opcode_o2,
  output logic [4:0]  reg_o1,
  output logic [4:0]  reg_o2,
  output logic [15:0] operand_o1,
  output logic [15:0] operand_o2,
  input  logic        branchResolved_i,
  input  logic        branchTaken_i,
  output logic        overflow_o
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        branch;
    logic        fmt;
    logic [6:0]  opcode;
    logic [4:0]  regno;
    logic [15:0] operand;
  } slot_t;

  typedef struct packed {
    slot_t s1;
    slot_t s2;
  } pair_t;

  typedef enum logic [2:0] {EMPTY, DUAL, SLOT1, SLOT2, BRANCH_WAIT} state_t;

  // A pair must be issued one slot at a time if slot 2 depends on slot 1,
  // or if slot 1 is a branch.
  function automatic logic serial_pair(input pair_t p);
    logic hazard;
    hazard = (p.s2.regno == p.s1.regno) ||
             (!p.s2.fmt && (p.s2.operand[4:0] == p.s1.regno));
    return hazard || p.s1.branch;
  endfunction

  pair_t           mem [QUEUE_DEPTH];
  pair_t           incoming;
  pair_t           head;
  pair_t           head_next;
  state_t          state;
  state_t          state_n;
  logic            done1, done2, pend;
  logic            done1_n, done2_n, pend_n;
  logic            valid1, valid2, valid1_n, valid2_n;
  logic            ovf;
  slot_t           out1, out2;
  logic [AW-1:0]   rd_ptr, wr_ptr, head_idx;
  logic [CW-1:0]   count, count_n, count_after_pop;
  logic            full, fire1, fire2, pop, push, drop, clear, eval;

  assign incoming = pair_t'({isBranch_i1, format_i1, opcode_i1, reg_i1, operand_i1,
                             isBranch_i2, format_i2, opcode_i2, reg_i2, operand_i2});
  assign head     = mem[rd_ptr];
  assign full     = (count == CW'(QUEUE_DEPTH));

  // Upstream backpressure: leave room for pairs already in the parser.
  assign stall_o = ((CW'(QUEUE_DEPTH) - count) <= CW'(STALL_MARGIN));

  // Next-state, queue bookkeeping and next issue-port values.
  always_comb begin
    state_n  = state;
    done1_n  = done1;
    done2_n  = done2;
    pend_n   = pend;
    pop      = 1'b0;
    eval     = 1'b0;
    clear    = 1'b0;
    fire1    = valid1 & issueReady_i1;
    fire2    = valid2 & issueReady_i2;

    if (flush_i) begin
      clear   = 1'b1;
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: eval = 1'b1;
        DUAL: begin
          if ((done1 | fire1) && (done2 | fire2)) begin
            pop = 1'b1;
            if (head.s2.branch) begin
              state_n = BRANCH_WAIT;
              pend_n  = 1'b0;
            end else begin
              eval = 1'b1;
            end
          end else begin
            done1_n = done1 | fire1;
            done2_n = done2 | fire2;
          end
        end
        SLOT1: begin
          if (fire1) begin
            if (head.s1.branch) begin
              state_n = BRANCH_WAIT;
              pend_n  = 1'b1;
            end else begin
              state_n = SLOT2;
            end
          end
        end
        SLOT2: begin
          if (fire2) begin
            pop = 1'b1;
            if (head.s2.branch) begin
              state_n = BRANCH_WAIT;
              pend_n  = 1'b0;
            end else begin
              eval = 1'b1;
            end
          end
        end
        BRANCH_WAIT: begin
          if (branchResolved_i) begin
            if (branchTaken_i) begin
              // Taken branch: everything queued (and arriving now) is wrong-path.
              clear   = 1'b1;
              state_n = EMPTY;
            end else if (pend) begin
              state_n = SLOT2;
            end else begin
              eval = 1'b1;
            end
          end
        end
        default: state_n = EMPTY;
      endcase
    end

    push = enable_i & ~clear & (~full | pop);
    drop = enable_i & ~clear & full & ~pop;

    count_after_pop = count - CW'(pop);
    count_n         = clear ? '0 : (count_after_pop + CW'(push));
    head_idx        = pop ? (rd_ptr + AW'(1)) : rd_ptr;
    head_next       = (count_after_pop == '0) ? incoming : mem[head_idx];

    if (eval) begin
      if (count_n == '0) begin
        state_n = EMPTY;
      end else if (serial_pair(head_next)) begin
        state_n = SLOT1;
      end else begin
        state_n = DUAL;
        done1_n = 1'b0;
        done2_n = 1'b0;
      end
    end

    valid1_n = ((state_n == DUAL) && !done1_n) || (state_n == SLOT1);
    valid2_n = ((state_n == DUAL) && !done2_n) || (state_n == SLOT2);
  end

  // State, pointers, sticky overflow and registered issue ports.
  always_ff @(posedge clock_i or negedge nReset_i) begin
    if (!nReset_i) begin
      state  <= EMPTY;
      done1  <= 1'b0;
      done2  <= 1'b0;
      pend   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      out1   <= '0;
      out2   <= '0;
    end else begin
      state  <= state_n;
      done1  <= done1_n;
      done2  <= done2_n;
      pend   <= pend_n;
      rd_ptr <= clear ? '0 : (rd_ptr + AW'(pop));
      wr_ptr <= clear ? '0 : (wr_ptr + AW'(push));
      count  <= count_n;
      ovf    <= ovf | drop;
      valid1 <= valid1_n;
      valid2 <= valid2_n;
      out1   <= head_next.s1;
      out2   <= head_next.s2;
    end
  end

  // Pair storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= incoming;
  end

  assign issueValid_o1 = valid1;
  assign issueValid_o2 = valid2;
  assign overflow_o    = ovf;
  assign isBranch_o1   = out1.branch;
  assign format_o1     = out1.fmt;
  assign opcode_o1     = out1.opcode;
  assign reg_o1        = out1.regno;
  assign operand_o1    = out1.operand;
  assign isBranch_o2   = out2.branch;
  assign format_o2     = out2.fmt;
  assign opcode_o2     = out2.opcode;
  assign reg_o2        = out2.regno;
  assign operand_o2    = out2.operand;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: the driver logs each cycle's stimulus,
// and the monitor replays it against a rule-level model of the pair queue.
module tb_issue_scheduler;

  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;

  typedef struct packed {
    logic        branch;
    logic        fmt;
    logic [6:0]  opcode;
    logic [4:0]  regno;
    logic [15:0] operand;
  } slot_t;

  typedef struct packed {
    slot_t s1;
    slot_t s2;
  } pair_t;

  typedef struct packed {
    logic  rst, en, fl, r1, r2, res, tk;
    pair_t p;
  } stim_t;

  logic        clock_i, nReset_i, flush_i, enable_i;
  logic        isBranch_i1, isBranch_i2, format_i1, format_i2;
  logic [6:0]  opcode_i1, opcode_i2;
  logic [4:0]  reg_i1, reg_i2;
  logic [15:0] operand_i1, operand_i2;
  logic        stall_o, issueValid_o1, issueValid_o2, issueReady_i1, issueReady_i2;
  logic        isBranch_o1, isBranch_o2, format_o1, format_o2;
  logic [6:0]  opcode_o1, opcode_o2;
  logic [4:0]  reg_o1, reg_o2;
  logic [15:0] operand_o1, operand_o2;
  logic        branchResolved_i, branchTaken_i, overflow_o;

  issue_scheduler #(.QUEUE_DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clock_i(clock_i), .nReset_i(nReset_i), .flush_i(flush_i), .enable_i(enable_i),
    .isBranch_i1(isBranch_i1), .isBranch_i2(isBranch_i2),
    .format_i1(format_i1), .format_i2(format_i2),
    .opcode_i1(opcode_i1), .opcode_i2(opcode_i2),
    .reg_i1(reg_i1), .reg_i2(reg_i2),
    .operand_i1(operand_i1), .operand_i2(operand_i2),
    .stall_o(stall_o), .issueValid_o1(issueValid_o1), .issueValid_o2(issueValid_o2),
    .issueReady_i1(issueReady_i1), .issueReady_i2(issueReady_i2),
    .isBranch_o1(isBranch_o1), .isBranch_o2(isBranch_o2),
    .format_o1(format_o1), .format_o2(format_o2),
    .opcode_o1(opcode_o1), .opcode_o2(opcode_o2),
    .reg_o1(reg_o1), .reg_o2(reg_o2),
    .operand_o1(operand_o1), .operand_o2(operand_o2),
    .branchResolved_i(branchResolved_i), .branchTaken_i(branchTaken_i),
    .overflow_o(overflow_o)
  );

  int total = 0;
  int passed = 0;

  stim_t stim_q[$];
  pair_t mq[$];        // pairs the scheduler should be holding, head first
  bit    md1, md2;     // head slot 1 / slot 2 already issued
  bit    mbw;          // a branch is outstanding
  bit    movf;         // sticky overflow expectation

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
  endtask

  function automatic bit serial_pair(input pair_t p);
    return (p.s2.regno == p.s1.regno) ||
           (!p.s2.fmt && (p.s2.operand[4:0] == p.s1.regno)) || p.s1.branch;
  endfunction

  function automatic slot_t mk_slot(input bit br, input bit f, input logic [6:0] op,
                                    input logic [4:0] rg, input logic [15:0] opd);
    return slot_t'({br, f, op, rg, opd});
  endfunction

  function automatic slot_t rand_slot();
    logic [15:0] o;
    o      = 16'($urandom);
    o[4:0] = 5'($urandom_range(0, 7));
    return mk_slot($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                   7'($urandom), 5'($urandom_range(0, 7)), o);
  endfunction

  function automatic stim_t mk_stim(input bit rst, input bit en, input bit fl,
                                    input bit r1, input bit r2, input bit res,
                                    input bit tk, input pair_t p);
    stim_t s;
    s.rst = rst; s.en = en; s.fl = fl; s.r1 = r1; s.r2 = r2;
    s.res = res; s.tk = tk; s.p = p;
    return s;
  endfunction

  // Drive one cycle of stimulus at the falling edge and log it for the monitor.
  task automatic cyc(input stim_t s);
    @(negedge clock_i);
    nReset_i         = !s.rst;
    enable_i         = s.en;
    flush_i          = s.fl;
    issueReady_i1    = s.r1;
    issueReady_i2    = s.r2;
    branchResolved_i = s.res;
    branchTaken_i    = s.tk;
    {isBranch_i1, format_i1, opcode_i1, reg_i1, operand_i1} = s.p.s1;
    {isBranch_i2, format_i2, opcode_i2, reg_i2, operand_i2} = s.p.s2;
    stim_q.push_back(s);
  endtask

  task automatic idle(input int n, input bit r1, input bit r2);
    for (int i = 0; i < n; i++) cyc(mk_stim(0, 0, 0, r1, r2, 0, 0, '0));
  endtask

  // Monitor: compare outputs against the model, then apply the coming edge.
  initial begin
    stim_t s;
    pair_t hp, gone;
    bit    e1, e2, f1, f2, popped, taken;
    forever begin
      @(negedge clock_i);
      #2;
      if (stim_q.size() != 0) begin
        s = stim_q.pop_front();
        if (s.rst) begin
          chk("rst_valid1", 64'(issueValid_o1), 64'(0));
          chk("rst_valid2", 64'(issueValid_o2), 64'(0));
          chk("rst_stall", 64'(stall_o), 64'(0));
          chk("rst_overflow", 64'(overflow_o), 64'(0));
          chk("rst_data1", 64'({isBranch_o1, format_o1, opcode_o1, reg_o1, operand_o1}), 64'(0));
          chk("rst_data2", 64'({isBranch_o2, format_o2, opcode_o2, reg_o2, operand_o2}), 64'(0));
          mq.delete();
          md1 = 0; md2 = 0; mbw = 0; movf = 0;
        end else begin
          hp = (mq.size() != 0) ? mq[0] : '0;
          e1 = (mq.size() != 0) && !mbw && !md1;
          e2 = (mq.size() != 0) && !mbw && !md2 && (!serial_pair(hp) || md1);
          chk("valid1", 64'(issueValid_o1), 64'(e1));
          chk("valid2", 64'(issueValid_o2), 64'(e2));
          chk("stall", 64'(stall_o), 64'((DEPTH - mq.size()) <= MARGIN));
          chk("overflow", 64'(overflow_o), 64'(movf));
          if (e1) chk("data1", 64'({isBranch_o1, format_o1, opcode_o1, reg_o1, operand_o1}), 64'(hp.s1));
          if (e2) chk("data2", 64'({isBranch_o2, format_o2, opcode_o2, reg_o2, operand_o2}), 64'(hp.s2));

          popped = 0;
          taken  = 0;
          if (s.fl) begin
            mq.delete();
            md1 = 0; md2 = 0; mbw = 0;
          end else begin
            if (mbw) begin
              if (s.res) begin
                mbw = 0;
                if (s.tk) begin
                  taken = 1;
                  mq.delete();
                  md1 = 0; md2 = 0;
                end
              end
            end else begin
              f1 = e1 && s.r1;
              f2 = e2 && s.r2;
              if (f1) md1 = 1;
              if (f2) md2 = 1;
              if (md1 && md2) begin
                gone = mq.pop_front();
                md1 = 0; md2 = 0; popped = 1;
                if (gone.s2.branch) mbw = 1;
              end else if (f1 && hp.s1.branch) begin
                mbw = 1;
              end
            end
            if (s.en && !taken) begin
              if (mq.size() < DEPTH) mq.push_back(s.p);
              else movf = 1;
            end
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    pair_t p;
    stim_t s;
    nReset_i = 1'b0; flush_i = 1'b0; enable_i = 1'b0;
    issueReady_i1 = 1'b0; issueReady_i2 = 1'b0;
    branchResolved_i = 1'b0; branchTaken_i = 1'b0;
    {isBranch_i1, format_i1, opcode_i1, reg_i1, operand_i1} = '0;
    {isBranch_i2, format_i2, opcode_i2, reg_i2, operand_i2} = '0;

    for (int i = 0; i < 3; i++) cyc(mk_stim(1, 0, 0, 0, 0, 0, 0, '0));

    // Independent pair into an empty queue, both units ready.
    p.s1 = mk_slot(0, 1, 7'h10, 5'd3, 16'h1234);
    p.s2 = mk_slot(0, 1, 7'h11, 5'd4, 16'h0003);
    cyc(mk_stim(0, 1, 0, 1, 1, 0, 0, p));
    idle(3, 1, 1);

    // Hazard pair: slot 2 reads slot 1's register.
    p.s1 = mk_slot(0, 1, 7'h20, 5'd5, 16'h00aa);
    p.s2 = mk_slot(0, 0, 7'h21, 5'd6, 16'h0005);
    cyc(mk_stim(0, 1, 0, 1, 1, 0, 0, p));
    idle(4, 1, 1);

    // Slot-1 branch, two more pairs queued, then resolved taken.
    p.s1 = mk_slot(1, 1, 7'h30, 5'd1, 16'h0100);
    p.s2 = mk_slot(0, 1, 7'h31, 5'd2, 16'h0200);
    cyc(mk_stim(0, 1, 0, 1, 1, 0, 0, p));
    p.s1 = mk_slot(0, 1, 7'h32, 5'd7, 16'h0300);
    cyc(mk_stim(0, 1, 0, 1, 1, 0, 0, p));
    p.s1 = mk_slot(0, 1, 7'h33, 5'd0, 16'h0400);
    cyc(mk_stim(0, 1, 0, 1, 1, 0, 0, p));
    idle(1, 1, 1);
    cyc(mk_stim(0, 0, 0, 1, 1, 1, 1, '0));
    idle(3, 1, 1);

    // Six back-to-back pairs with no unit ready: stall, then overflow.
    for (int i = 0; i < 6; i++) begin
      p.s1 = mk_slot(0, 1, 7'(8'h40 + i), 5'd1, 16'(i));
      p.s2 = mk_slot(0, 1, 7'(8'h50 + i), 5'd2, 16'(i));
      cyc(mk_stim(0, 1, 0, 0, 0, 0, 0, p));
    end
    idle(3, 0, 0);
    idle(12, 1, 1);

    // Flush together with a push while dual-issuing and unit 2 is stalled.
    p.s1 = mk_slot(0, 1, 7'h60, 5'd8, 16'h0);
    p.s2 = mk_slot(0, 1, 7'h61, 5'd9, 16'h0);
    cyc(mk_stim(0, 1, 0, 1, 0, 0, 0, p));
    p.s1.opcode = 7'h62;
    cyc(mk_stim(0, 1, 1, 1, 0, 0, 0, p));
    idle(3, 1, 1);

    // Asynchronous reset in the middle of a slot-2 issue.
    p.s1 = mk_slot(0, 1, 7'h70, 5'd10, 16'h0);
    p.s2 = mk_slot(0, 1, 7'h71, 5'd10, 16'h0);
    cyc(mk_stim(0, 1, 0, 0, 0, 0, 0, p));
    cyc(mk_stim(0, 0, 0, 1, 0, 0, 0, '0));
    cyc(mk_stim(0, 0, 0, 0, 0, 0, 0, '0));
    cyc(mk_stim(1, 0, 0, 0, 1, 0, 0, '0));
    idle(4, 1, 1);

    // Randomized traffic with small register ranges to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      p.s1 = rand_slot();
      p.s2 = rand_slot();
      s = mk_stim($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)), p);
      cyc(s);
    end
    idle(4, 1, 1);

    @(negedge clock_i);
    #5;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4: number of instruction-pair entries held (power of two, at least 4).
REQ-002 SHALL have parameter STALL_MARGIN, default 2: number of free entries reserved for pairs already in flight in the parser.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clock_i  in  1  rising-edge clock.
REQ-004 SHALL have nReset_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have flush_i  in  1  synchronous flush; discards all queued and pending instructions.
REQ-006 SHALL have enable_i  in  1  a parsed pair is present this cycle.
REQ-007 SHALL have isBranch_i1/_i2, format_i1/_i2  in  1 each  per-slot branch bit and format bit (0 = 19b, 1 = 30b).
REQ-008 SHALL have opcode_i1/_i2  in  7 each, reg_i1/_i2  in  5 each, operand_i1/_i2  in  16 each  per-slot fields.
REQ-009 SHALL have stall_o  out  1  upstream must stop fetching new pairs.
REQ-010 SHALL have issueValid_o1/_o2  out  1 each  port 1 / port 2 hold a valid instruction.
REQ-011 SHALL have issueReady_i1/_i2  in  1 each  execution unit 1 / unit 2 accepts this cycle.
REQ-012 SHALL have issue bus per port: isBranch_o, format_o (1 each), opcode_o (7), reg_o (5), operand_o (16), each with suffix _o1 / _o2.
REQ-013 SHALL have branchResolved_i  in  1 and branchTaken_i  in  1  outcome of the outstanding branch.
REQ-014 SHALL have overflow_o  out  1  sticky flag: a pair was dropped because the queue was full.

Function
REQ-015 SHALL push the pair into the FIFO on a rising edge when enable_i=1, the FIFO is not full, and flush_i=0.
REQ-016 SHALL drop a pair that arrives while the FIFO is full, leave the FIFO unchanged, and set overflow_o=1 until reset.
REQ-017 SHALL assert stall_o combinationally while the number of free entries is at most STALL_MARGIN.
REQ-018 SHALL drive the issue ports from the head entry only; a pair pushed into an empty FIFO at edge N SHALL appear on the ports in cycle N+1 (no bypass).
REQ-019 SHALL count an issue on a port only when that port's issueValid and issueReady are both 1 at the rising edge.
REQ-020 SHALL implement state machine states: EMPTY, DUAL, SLOT1, SLOT2, BRANCH_WAIT.
REQ-021 SHALL treat the head pair as having a hazard when reg_i2==reg_i1, or when format2=0 and operand2[4:0]==reg1.
REQ-022 SHALL enter DUAL when the head has no hazard and slot 1 is not a branch: both issueValid=1; each slot retires independently when accepted; the pair pops once both slots have retired.
REQ-023 SHALL enter SLOT1 when the head has a hazard or slot 1 is a branch: only issueValid_o1=1.
REQ-024 SHALL, in SLOT1, on acceptance of slot 1, go to BRANCH_WAIT if slot 1 is a branch, otherwise to SLOT2.
REQ-025 SHALL, in SLOT2, drive only issueValid_o2=1 with slot 2; on acceptance pop the pair and go to BRANCH_WAIT if slot 2 is a branch, otherwise re-evaluate the next head.
REQ-026 SHALL, in DUAL, go to BRANCH_WAIT after the pop if slot 2 was a branch.
REQ-027 SHALL drive both issueValid=0 in BRANCH_WAIT.
REQ-028 SHALL, when branchResolved_i=1 with branchTaken_i=1, empty the FIFO, including any unissued slot 2 of the branch pair, and go to EMPTY.
REQ-029 SHALL, when branchResolved_i=1 with branchTaken_i=0, go to SLOT2 if the branch pair's slot 2 is unissued, otherwise re-evaluate the head.
REQ-030 SHALL ignore branchResolved_i outside BRANCH_WAIT.
REQ-031 SHALL have flush_i take priority over a push, an issue and branch resolution in the same cycle: empty the FIFO, go to EMPTY, both issueValid=0 next cycle, and leave overflow_o unchanged.
REQ-032 SHALL allow a push and a pop in the same cycle when the FIFO is full, with the push accepted and no overflow.
REQ-033 SHALL wrap read and write pointers modulo QUEUE_DEPTH and keep occupancy in log2(QUEUE_DEPTH)+1 bits.

Reset
REQ-034 SHALL, while nReset_i=0, immediately force state EMPTY, pointers and occupancy 0, issueValid_o1/_o2=0, stall_o=0 and overflow_o=0, regardless of clock.
REQ-035 SHALL reset issue data outputs to 0, and SHALL drop an in-progress pair or pending branch on reset mid-operation with no issue afterwards.

Verification
REQ-036 SHALL cover: independent pair (reg1=3, reg2=4, format2=1) into empty FIFO with both ports ready -> both ports valid in cycle N+1 and pair popped at the following edge.
REQ-037 SHALL cover: hazard pair (reg1=5, format2=0, operand2=0x0005) -> slot 1 alone on port 1, slot 2 on port 2 the cycle after acceptance, never both valid together.
REQ-038 SHALL cover: slot-1 branch, then branchResolved_i=1 with branchTaken_i=1 after 3 cycles with 2 more pairs queued -> slot 2 never issued, FIFO empty, state EMPTY.
REQ-039 SHALL cover: 6 back-to-back pairs with both ready=0 and DEPTH=4 -> stall_o high once 2 entries are used, 5th and 6th pairs dropped, overflow_o=1 and sticky.
REQ-040 SHALL cover: flush_i and enable_i asserted together while in DUAL with unit 2 not ready -> nothing queued, both valid=0 next cycle.
REQ-041 SHALL cover: nReset_i asserted low asynchronously mid-SLOT2 -> outputs 0 before the next clock edge, no issue after release.
